// File: rtl/matvec_operand_loader_if.sv
// Handshake and coefficient bus for matvec_operand_loader.
// master: the producer/host/consumer side; slave: the loader itself.
interface matvec_operand_loader_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic               coef_we;
  logic [3:0]         coef_addr;
  logic [WIDTH-1:0]   coef_data;
  logic               coef_commit;
  logic [3*WIDTH-1:0] row_out;
  logic [3*WIDTH-1:0] vec_out;
  logic [1:0]         row_idx;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    output in_data, in_valid, coef_we, coef_addr, coef_data, coef_commit, out_ready,
    input  in_ready, row_out, vec_out, row_idx, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, coef_we, coef_addr, coef_data, coef_commit, out_ready,
    output in_ready, row_out, vec_out, row_idx, out_valid, busy
  );
endinterface

// File: rtl/matvec_operand_loader.sv
// Operand loader for the 3x3 matrix-vector dot-product stage.
// Collects three serial samples into a vector, then issues the three rows of the
// active coefficient matrix alongside it, one per handshake. Coefficients are
// written into a shadow bank and copied to the active bank at a vector boundary.
// Optional: define MATVEC_LOADER_DOUBLE_BUFFER_EN to add a fill buffer so the next
// vector is collected while the current one is issued.
module matvec_operand_loader #(
  parameter int unsigned WIDTH = 16
) (
  input logic                     system1000,
  input logic                     system1000_rstn,
  matvec_operand_loader_if.slave  bus
);

  localparam int unsigned VecW = 3 * WIDTH;

  typedef logic [8:0][WIDTH-1:0] bank_t;
  typedef enum logic [0:0] {StCollect, StIssue} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [VecW-1:0] vec_q, vec_d;
  logic [VecW-1:0] row_q, row_d;
  bank_t           active_q, active_d;
  bank_t           shadow_q, shadow_d;
  logic            pending_q, pending_d;
  logic            in_ready, out_valid, in_fire, out_fire, boundary;
`ifdef MATVEC_LOADER_DOUBLE_BUFFER_EN
  logic [VecW-1:0] fill_q, fill_d;
  logic [1:0]      cnt_acc;
`endif

  function automatic bank_t identity_bank();
    bank_t b;
    b    = '0;
    b[0] = WIDTH'(1);
    b[4] = WIDTH'(1);
    b[8] = WIDTH'(1);
    return b;
  endfunction

  // Element 0 of the row lands in the top slice.
  function automatic logic [VecW-1:0] row_sel(input bank_t b, input logic [1:0] r);
    logic [VecW-1:0] v;
    unique case (r)
      2'd0:    v = {b[0], b[1], b[2]};
      2'd1:    v = {b[3], b[4], b[5]};
      default: v = {b[6], b[7], b[8]};
    endcase
    return v;
  endfunction

  // First sample goes to the top slice.
  function automatic logic [VecW-1:0] write_slot(input logic [VecW-1:0] v,
                                                 input logic [1:0] idx,
                                                 input logic [WIDTH-1:0] d);
    logic [VecW-1:0] r;
    r = v;
    unique case (idx)
      2'd0:    r[VecW-1 -: WIDTH]    = d;
      2'd1:    r[2*WIDTH-1 -: WIDTH] = d;
      default: r[WIDTH-1:0]          = d;
    endcase
    return r;
  endfunction

  // Next-state logic for collection, row issue and vector-boundary detection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_idx_d = row_idx_q;
    vec_d     = vec_q;
    boundary  = 1'b0;
`ifdef MATVEC_LOADER_DOUBLE_BUFFER_EN
    fill_d    = fill_q;
    cnt_acc   = cnt_q;
    // Stall input only when the fill buffer already holds a complete vector.
    in_ready  = (state_q == StCollect) || (cnt_q != 2'd3);
`else
    in_ready  = (state_q == StCollect);
`endif
    out_valid = (state_q == StIssue);
    in_fire   = bus.in_valid & in_ready;
    out_fire  = out_valid & bus.out_ready;

    unique case (state_q)
      StCollect: begin
        if (in_fire) begin
`ifdef MATVEC_LOADER_DOUBLE_BUFFER_EN
          fill_d = write_slot(fill_q, cnt_q, bus.in_data);
`else
          vec_d  = write_slot(vec_q, cnt_q, bus.in_data);
`endif
          if (cnt_q == 2'd2) begin
`ifdef MATVEC_LOADER_DOUBLE_BUFFER_EN
            vec_d = fill_d;
`endif
            cnt_d     = 2'd0;
            state_d   = StIssue;
            row_idx_d = 2'd0;
            boundary  = 1'b1;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      StIssue: begin
`ifdef MATVEC_LOADER_DOUBLE_BUFFER_EN
        if (in_fire) begin
          fill_d  = write_slot(fill_q, cnt_q, bus.in_data);
          cnt_acc = cnt_q + 2'd1;
        end
        cnt_d = cnt_acc;
`endif
        if (out_fire) begin
          if (row_idx_q == 2'd2) begin
            row_idx_d = 2'd0;
`ifdef MATVEC_LOADER_DOUBLE_BUFFER_EN
            // A complete fill buffer (counting a same-cycle third sample) swaps in.
            if (cnt_acc == 2'd3) begin
              vec_d    = fill_d;
              cnt_d    = 2'd0;
              boundary = 1'b1;
            end else begin
              state_d = StCollect;
            end
`else
            state_d = StCollect;
`endif
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end
      end
      default: state_d = StCollect;
    endcase
  end

  // Coefficient banks: shadow writes, commit-pending tracking and boundary copy.
  always_comb begin
    shadow_d = shadow_q;
    if (bus.coef_we && (bus.coef_addr <= 4'd8)) begin
      shadow_d[bus.coef_addr] = bus.coef_data;
    end
    // The copy takes the pre-write shadow; a commit on the copy edge re-arms.
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = bus.coef_commit;
    end else begin
      active_d  = active_q;
      pending_d = pending_q | bus.coef_commit;
    end
    // Registered row mux; inputs are constant while a pair is stalled.
    row_d = row_sel(active_d, row_idx_d);
  end

  // Output drive.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.row_out   = row_q;
    bus.vec_out   = vec_q;
    bus.row_idx   = row_idx_q;
    bus.busy      = !((state_q == StCollect) && (cnt_q == 2'd0));
  end

  // State registers.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q   <= StCollect;
      cnt_q     <= 2'd0;
      row_idx_q <= 2'd0;
      vec_q     <= '0;
      row_q     <= row_sel(identity_bank(), 2'd0);
      active_q  <= identity_bank();
      shadow_q  <= identity_bank();
      pending_q <= 1'b0;
`ifdef MATVEC_LOADER_DOUBLE_BUFFER_EN
      fill_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_idx_q <= row_idx_d;
      vec_q     <= vec_d;
      row_q     <= row_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
`ifdef MATVEC_LOADER_DOUBLE_BUFFER_EN
      fill_q    <= fill_d;
`endif
    end
  end

endmodule

// File: tb/tb_matvec_operand_loader.sv
// Bench for matvec_operand_loader: directed steps plus a random phase, checked
// against a transaction-level model (sample queue, vector queue, coefficient arrays).
module tb_matvec_operand_loader;
  localparam int unsigned W  = 16;
  localparam int unsigned VW = 3 * W;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  matvec_operand_loader_if #(.WIDTH(W)) bus ();
  matvec_operand_loader #(.WIDTH(W)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .bus             (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0]  m_active [9];
  logic [W-1:0]  m_shadow [9];
  bit            m_pending;
  logic [W-1:0]  m_fill [$];
  logic [VW-1:0] m_vecs [$];
  logic [VW-1:0] m_rows [3];
  bit            m_issuing;
  int            m_row;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 9; i++) begin
      m_active[i] = (i % 4 == 0) ? W'(1) : W'(0);
      m_shadow[i] = (i % 4 == 0) ? W'(1) : W'(0);
    end
    m_pending = 0;
    m_fill.delete();
    m_vecs.delete();
    m_issuing = 0;
    m_row     = 0;
  endtask

  function automatic bit exp_in_ready();
`ifdef MATVEC_LOADER_DOUBLE_BUFFER_EN
    return m_vecs.size() < 2;
`else
    return m_vecs.size() == 0;
`endif
  endfunction

  // One clock: drive inputs, check in_ready, clock, update model, check outputs.
  task automatic cycle(input bit iv, input logic [W-1:0] id, input bit ordy,
                       input bit we, input logic [3:0] addr, input logic [W-1:0] cd,
                       input bit cm);
    bit in_fire, out_fire;
    bus.in_valid    = iv;
    bus.in_data     = id;
    bus.out_ready   = ordy;
    bus.coef_we     = we;
    bus.coef_addr   = addr;
    bus.coef_data   = cd;
    bus.coef_commit = cm;
    #1;
    chk("in_ready", bus.in_ready, exp_in_ready());
    in_fire  = iv && exp_in_ready();
    out_fire = m_issuing && ordy;
    @(posedge clk);
    #1;
    if (out_fire) begin
      m_row++;
      if (m_row == 3) begin
        void'(m_vecs.pop_front());
        m_issuing = 0;
        m_row     = 0;
      end
    end
    if (in_fire) begin
      m_fill.push_back(id);
      if (m_fill.size() == 3) begin
        m_vecs.push_back({m_fill[0], m_fill[1], m_fill[2]});
        m_fill.delete();
      end
    end
    if (!m_issuing && m_vecs.size() > 0) begin
      if (m_pending) begin
        m_active  = m_shadow;
        m_pending = cm;
      end else if (cm) begin
        m_pending = 1;
      end
      m_issuing = 1;
      m_row     = 0;
      for (int r = 0; r < 3; r++)
        m_rows[r] = {m_active[3*r], m_active[3*r+1], m_active[3*r+2]};
    end else if (cm) begin
      m_pending = 1;
    end
    if (we && addr < 4'd9) m_shadow[addr] = cd;

    chk("out_valid", bus.out_valid, m_issuing);
    chk("row_idx", bus.row_idx, m_issuing ? m_row : 0);
    chk("busy", bus.busy, (m_vecs.size() != 0) || (m_fill.size() != 0));
    if (m_issuing) begin
      chk("row_out", bus.row_out, m_rows[m_row]);
      chk("vec_out", bus.vec_out, m_vecs[0]);
    end
  endtask

  task automatic idle(input bit ordy);
    cycle(0, '0, ordy, 0, '0, '0, 0);
  endtask

  task automatic send3(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    cycle(1, a, 1, 0, '0, '0, 0);
    cycle(1, b, 1, 0, '0, '0, 0);
    cycle(1, c, 1, 0, '0, '0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (m_issuing || m_vecs.size() > 0); i++) idle(1);
    chk("drain_idle", bus.out_valid, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_row_idx"}, bus.row_idx, 0);
    chk({tag, "_vec_out"}, bus.vec_out, 0);
    chk({tag, "_row_out"}, bus.row_out, 48'h0001_0000_0000);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    bus.coef_we = 0; bus.coef_addr = '0; bus.coef_data = '0; bus.coef_commit = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rstn = 1;

    // Identity matrix, vector 1,2,3
    send3(16'd1, 16'd2, 16'd3);
    chk("t1_first_valid", bus.out_valid, 1);
    chk("t1_row0", bus.row_out, 48'h0001_0000_0000);
    chk("t1_vec", bus.vec_out, 48'h0001_0002_0003);
    idle(1);
    chk("t1_row1", bus.row_out, 48'h0000_0001_0000);
    idle(1);
    chk("t1_row2", bus.row_out, 48'h0000_0000_0001);
    chk("t1_idx2", bus.row_idx, 2);
    drain();

    // Shadow write + commit during issue: applies to the following vector only
    send3(16'd4, 16'd5, 16'd6);
    cycle(0, '0, 0, 1, 4'd3, 16'hFFFF, 0);
    cycle(0, '0, 0, 1, 4'd4, 16'd5, 0);
    cycle(0, '0, 0, 1, 4'd5, 16'd7, 1);
    idle(1);
    chk("t2_row1_old", bus.row_out, 48'h0000_0001_0000);
    drain();
    send3(16'd1, 16'd1, 16'd1);
    idle(1);
    chk("t2_row1_new", bus.row_out, 48'hFFFF_0005_0007);
    drain();

    // Backpressure at row 1
    send3(16'h10, 16'h20, 16'h30);
    idle(1);
    repeat (5) cycle(1, 16'h0BAD, 0, 0, '0, '0, 0);
    chk("t3_hold_idx", bus.row_idx, 1);
    chk("t3_hold_vec", bus.vec_out, 48'h0010_0020_0030);
`ifndef MATVEC_LOADER_DOUBLE_BUFFER_EN
    chk("t3_in_ready_low", bus.in_ready, 0);
`endif
    idle(1);
    chk("t3_resume_idx", bus.row_idx, 2);
    drain();

    // Asynchronous reset mid-vector
    cycle(1, 16'h11, 1, 0, '0, '0, 0);
    cycle(1, 16'h22, 1, 0, '0, '0, 0);
    bus.in_valid = 0;
    rstn = 0;
    #2;
    check_reset_values("midrst");
    m_reset();
    @(posedge clk);
    #1;
    rstn = 1;
    send3(16'd7, 16'd8, 16'd9);
    chk("t4_vec", bus.vec_out, 48'h0007_0008_0009);
    idle(1);
    chk("t4_row1_identity", bus.row_out, 48'h0000_0001_0000);
    drain();

    // Out-of-range write ignored; commit on the copy edge re-arms
    cycle(0, '0, 1, 1, 4'd12, 16'hBEEF, 1);
    send3(16'd1, 16'd2, 16'd3);
    chk("t5_addr12_noop", bus.row_out, 48'h0001_0000_0000);
    drain();
    cycle(0, '0, 1, 1, 4'd0, 16'h0042, 1);
    cycle(1, 16'd1, 1, 0, '0, '0, 0);
    cycle(1, 16'd2, 1, 0, '0, '0, 0);
    cycle(1, 16'd3, 1, 1, 4'd0, 16'h0099, 1);
    chk("t5_copy_prewrite", bus.row_out, 48'h0042_0000_0000);
    drain();
    send3(16'd4, 16'd5, 16'd6);
    chk("t5_recommit", bus.row_out, 48'h0099_0000_0000);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)), W'($urandom),
            ($urandom_range(0, 15) == 0));
    end
    drain();

`ifdef MATVEC_LOADER_DOUBLE_BUFFER_EN
    // Continuous streaming: one pair per cycle once the first vector is in
    for (int i = 0; i < 3; i++) cycle(1, W'(i + 1), 1, 0, '0, '0, 0);
    for (int i = 0; i < 15; i++) begin
      cycle(1, W'($urandom), 1, 0, '0, '0, 0);
      chk("db_no_gap", bus.out_valid, 1);
    end
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
